// File: rtl/bin2onehot_bbm_if.sv
// ============================================================================
// Module      : bin2onehot_bbm_if
// Description : Code-in / switch-drive-out bundle for bin2onehot_bbm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin2onehot_bbm_if #(
    parameter int WIDTH = 8
);
    localparam int c_bw = $clog2(WIDTH);

    logic             clr_i;
    logic             valid_i;
    logic [c_bw-1:0]  binary_i;
    logic             ready_o;
    logic [WIDTH-1:0] onehot_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output clr_i, valid_i, binary_i,
        input  ready_o, onehot_o, busy_o, err_o
    );

    modport slave (
        input  clr_i, valid_i, binary_i,
        output ready_o, onehot_o, busy_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/bin2onehot_bbm.sv
// ============================================================================
// Module      : bin2onehot_bbm
// Description : Binary-to-one-hot switch driver with break-before-make gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2onehot_bbm #(
    parameter int WIDTH       = 8,
    parameter int DEAD_CYCLES = 2
) (
    input  wire             clk_i,
    input  wire             rst_ni,
    bin2onehot_bbm_if.slave bus
);
    localparam int c_bw    = $clog2(WIDTH);
    localparam int c_cnt_w = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hold = 2'd1;
    localparam logic [1:0] c_dead = 2'd2;

    localparam logic [WIDTH-1:0]   c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_bw:0]      c_lim      = (c_bw+1)'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DEAD_CYCLES - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_onehot;
    logic [c_bw-1:0]    r_code;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    logic w_ready;
    logic w_xfer;
    logic w_in_range;

    assign w_ready    = (r_state != c_dead);
    assign w_xfer     = bus.valid_i && w_ready;
    assign w_in_range = ({1'b0, bus.binary_i} < c_lim);

    // r_code holds the driven code in HOLD and the pending code in DEAD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= c_idle;
            r_onehot <= '0;
            r_code   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else if (bus.clr_i) begin
            r_state  <= c_idle;
            r_onehot <= '0;
            r_code   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_xfer && !w_in_range;
            case (r_state)
                c_idle: begin
                    if (w_xfer && w_in_range) begin
                        r_onehot <= c_one << bus.binary_i;
                        r_code   <= bus.binary_i;
                        r_state  <= c_hold;
                    end
                end
                c_hold: begin
                    if (w_xfer && w_in_range && (bus.binary_i != r_code)) begin
                        r_onehot <= '0;
                        r_code   <= bus.binary_i;
                        r_cnt    <= c_cnt_load;
                        r_state  <= c_dead;
                    end
                end
                c_dead: begin
                    if (r_cnt == '0) begin
                        r_onehot <= c_one << r_code;
                        r_state  <= c_hold;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_idle;
                    r_onehot <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.busy_o   = (r_state == c_dead);
    assign bus.onehot_o = r_onehot;
    assign bus.err_o    = r_err;

endmodule

`default_nettype wire

// File: doc/bin2onehot_bbm.md
BIN2ONEHOT_BBM -- requirements
Module: bin2onehot_bbm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of one-hot output lines, legal range 2 or more.
REQ-002 The block SHALL have parameter DEAD_CYCLES, default 2: number of all-zero cycles inserted between two different one-hot codes, legal range 1 or more.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port clr_i, input, 1 bit: synchronous clear of the outputs to all-zero.
REQ-006 The block SHALL have port valid_i, input, 1 bit: binary_i carries a code.
REQ-007 The block SHALL have port binary_i, input, $clog2(WIDTH) bits: binary switch index.
REQ-008 The block SHALL have port ready_o, output, 1 bit: block accepts a code this cycle.
REQ-009 The block SHALL have port onehot_o, output, WIDTH bits: registered one-hot switch drive.
REQ-010 The block SHALL have port busy_o, output, 1 bit: dead-time gap in progress.
REQ-011 The block SHALL have port err_o, output, 1 bit: one-cycle pulse on an out-of-range code.

Function
REQ-012 A transfer SHALL occur on a rising edge where valid_i=1 and ready_o=1; binary_i is sampled only on a transfer.
REQ-013 The FSM SHALL have exactly three states: IDLE (onehot_o=0), HOLD (driving stored code), DEAD (onehot_o=0, counting).
REQ-014 ready_o SHALL be 1 in IDLE and HOLD and 0 in DEAD; busy_o SHALL be 1 only in DEAD; both outputs are decoded from registered state.
REQ-015 IDLE with a transfer of code c in cycle n SHALL produce onehot_o = 1<<c from cycle n+1 and enter HOLD, with no dead time.
REQ-016 HOLD with a transfer of the code currently driven SHALL leave onehot_o and the state unchanged, with no gap.
REQ-017 HOLD with a transfer of a different code c in cycle n SHALL drive onehot_o=0 and ready_o=0 in cycles n+1..n+DEAD_CYCLES, then onehot_o = 1<<c and HOLD from cycle n+DEAD_CYCLES+1.
REQ-018 The dead-time counter SHALL be wide enough for DEAD_CYCLES, load on entry to DEAD, and not wrap.
REQ-019 onehot_o SHALL never change directly from one nonzero code to a different nonzero code, and popcount(onehot_o) SHALL be at most 1 in every cycle.
REQ-020 A transfer with binary_i >= WIDTH (possible only for non-power-of-2 WIDTH) SHALL pulse err_o high for exactly one cycle (cycle n+1), and the code is dropped.
REQ-021 A dropped out-of-range code SHALL leave the state, onehot_o and the counter unchanged.
REQ-022 When clr_i=1 at an edge, from any state, the next cycle SHALL have onehot_o=0 and state IDLE, with the counter and pending code discarded.
REQ-023 clr_i SHALL take priority over a simultaneous transfer, which is ignored.
REQ-024 The block SHALL not raise err_o on a transfer that coincides with clr_i=1.
REQ-025 onehot_o and err_o SHALL be driven directly from flip-flops, with no combinational path from any input to onehot_o.

Reset
REQ-026 While rst_ni=0, the block SHALL immediately and asynchronously force onehot_o=0, err_o=0, busy_o=0 and state IDLE, and clear the counter and stored code.
REQ-027 While rst_ni=0, ready_o SHALL be 1.
REQ-028 After rst_ni deasserts, the first transfer SHALL be accepted on the first rising edge.
REQ-029 Reset asserted mid-DEAD SHALL abandon the pending code; after release, the pending code is not driven.

Verification (WIDTH=8, DEAD_CYCLES=2 unless noted)
REQ-030 Reset release -> onehot_o=0x00, ready_o=1, busy_o=0, err_o=0.
REQ-031 IDLE, transfer code 3 in cycle n -> onehot_o=0x08 in cycle n+1, busy_o never 1.
REQ-032 HOLD 0x08, transfer code 5 in cycle n -> onehot_o=0x00 with ready_o=0 and busy_o=1 in cycles n+1 and n+2; onehot_o=0x20 with ready_o=1 in cycle n+3.
REQ-033 HOLD 0x20, transfer code 5 again -> onehot_o stays 0x20 with no zero cycle; valid_i held high during DEAD -> no transfer until ready_o=1.
REQ-034 WIDTH=6, HOLD 0x04, transfer code 7 -> err_o=1 for one cycle, onehot_o stays 0x04.
REQ-035 clr_i=1 in the second DEAD cycle, together with valid_i=1 -> onehot_o=0 and IDLE with the new code ignored; separately, rst_ni=0 mid-DEAD -> onehot_o=0 without a clock edge.
REQ-036 The bench SHALL check the invariants of REQ-019 on every cycle of every scenario.
